bist_led_engine: RTL

Parametrised next-generation LED built-in-self-test pattern engine for board bring-up. Drives an LED bank of configurable width with one of several selectable test patterns, advanced by an internal prescaled tick. Adds LFSR, ping-pong, blink, hold/freeze and an auto-sweep mode that cycles all patterns and flags completion. Sits between the board mode switches and the LED pins.

---
 rtl/bist_led_pkg.sv | 77 +++++++
 rtl/bist_led_engine_if.sv | 31 +++
 rtl/bist_prescaler.sv | 55 +++++
 rtl/bist_led_engine.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bist_led_pkg.sv
// -----------------------------------------------------------------------------
// bist_led_pkg
// Shared definitions for the LED built-in-self-test engine:
//   - mode encodings MODE_OFF..MODE_SWEEP (plus the reserved code)
//   - sweep FSM state type
//   - lfsr_taps(): Fibonacci tap mask per LED width (4..32); bit i set means
//     led[i] feeds the XOR that is shifted into the MSB
//   - mode_seed(): value loaded into the LED register when a mode starts
// -----------------------------------------------------------------------------
package bist_led_pkg;

  localparam logic [2:0] MODE_OFF   = 3'b000;
  localparam logic [2:0] MODE_WALK  = 3'b001;
  localparam logic [2:0] MODE_COUNT = 3'b010;
  localparam logic [2:0] MODE_LFSR  = 3'b011;
  localparam logic [2:0] MODE_PING  = 3'b100;
  localparam logic [2:0] MODE_BLINK = 3'b101;
  localparam logic [2:0] MODE_SWEEP = 3'b110;
  localparam logic [2:0] MODE_RSVD  = 3'b111;

  typedef enum logic [1:0] {
    SW_IDLE,
    SW_RUN,
    SW_ADVANCE
  } sweep_state_e;

  // Maximal-length tap sets, mirrored so a right shift with MSB feedback works
  // (polynomial tap t maps to bit w-t).
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    logic [31:0] m;
    case (w)
      4:       m = 32'h0000_0003;
      5:       m = 32'h0000_0005;
      6:       m = 32'h0000_0003;
      7:       m = 32'h0000_0003;
      8:       m = 32'h0000_001D;
      9:       m = 32'h0000_0011;
      10:      m = 32'h0000_0009;
      11:      m = 32'h0000_0005;
      12:      m = 32'h0000_0941;
      13:      m = 32'h0000_1601;
      14:      m = 32'h0000_2A01;
      15:      m = 32'h0000_0003;
      16:      m = 32'h0000_002D;
      17:      m = 32'h0000_0009;
      18:      m = 32'h0000_0081;
      19:      m = 32'h0006_2001;
      20:      m = 32'h0000_0009;
      21:      m = 32'h0000_0005;
      22:      m = 32'h0000_0003;
      23:      m = 32'h0000_0021;
      24:      m = 32'h0000_0087;
      25:      m = 32'h0000_0009;
      26:      m = 32'h0310_0001;
      27:      m = 32'h0640_0001;
      28:      m = 32'h0000_0009;
      29:      m = 32'h0000_0005;
      30:      m = 32'h2500_0001;
      31:      m = 32'h0000_0009;
      32:      m = 32'hC000_0401;
      default: m = 32'h0000_0003;
    endcase
    return m;
  endfunction

  // lfsr_seed is already truncated to the bank width and forced non-zero.
  function automatic logic [31:0] mode_seed(input logic [2:0] m, input logic [31:0] lfsr_seed);
    logic [31:0] s;
    case (m)
      MODE_WALK, MODE_PING, MODE_SWEEP: s = 32'h0000_0001;
      MODE_LFSR:                        s = lfsr_seed;
      default:                          s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bist_led_engine_if.sv
// -----------------------------------------------------------------------------
// bist_led_engine_if
// Groups the mode-switch inputs and LED-side outputs of the BIST engine.
//   mode[2:0]        pattern select (from switches)
//   hold             freeze pattern and prescaler
//   led[LED_W-1:0]   registered LED drive
//   tick             one-clock pulse when led shows a freshly stepped value
//   mode_active[2:0] pattern currently applied (sub-mode while sweeping)
//   sweep_done       one-clock pulse at the end of each full sweep
//   signature        MISR signature, present only with BIST_MISR_EN defined
// master: switch/board side; slave: the engine.
// -----------------------------------------------------------------------------
interface bist_led_engine_if #(
  parameter int unsigned LED_W = 16
);
  logic [2:0]       mode;
  logic             hold;
  logic [LED_W-1:0] led;
  logic             tick;
  logic [2:0]       mode_active;
  logic             sweep_done;
`ifdef BIST_MISR_EN
  logic [LED_W-1:0] signature;

  modport master (output mode, hold, input led, tick, mode_active, sweep_done, signature);
  modport slave  (input mode, hold, output led, tick, mode_active, sweep_done, signature);
`else
  modport master (output mode, hold, input led, tick, mode_active, sweep_done);
  modport slave  (input mode, hold, output led, tick, mode_active, sweep_done);
`endif
endinterface

// File: rtl/bist_prescaler.sv
// -----------------------------------------------------------------------------
// bist_prescaler
// Counts 0..DIV-1 and pulses step_o combinationally on the edge where the
// count wraps, so the pattern steps on that same edge.
//   clk, rst  clock, synchronous active-high reset
//   clear_i   restart the count from 0 (mode change); suppresses step_o
//   hold_i    freeze the count; suppresses step_o
//   step_o    step enable for the pattern register
// -----------------------------------------------------------------------------
module bist_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic hold_i,
  output logic step_o
);
  localparam int unsigned    CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_q;
  logic          restart;

  // Releasing hold restarts the count so the first tick after release is a
  // full DIV clocks away, just like after a mode change.
  assign restart = clear_i | (hold_q & ~hold_i);

  always_comb begin
    cnt_d  = cnt_q;
    step_o = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (!hold_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        step_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      hold_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_i;
    end
  end

endmodule

// File: rtl/bist_led_engine.sv
// -----------------------------------------------------------------------------
// bist_led_engine
// LED bring-up pattern engine: off / walk / count / LFSR / ping-pong / blink,
// plus an auto-sweep that cycles walk..blink for SWEEP_STEPS ticks each and
// pulses sweep_done after blink. Patterns step on a prescaled tick.
//   clk     system clock
//   rst     synchronous active-high reset
//   led_if  slave modport of bist_led_engine_if (mode, hold in; led, tick,
//           mode_active, sweep_done out)
// Optional: define BIST_MISR_EN to add a MISR signature output on led_if,
// using the LFSR taps and folding in the post-step led value on every tick.
// -----------------------------------------------------------------------------
module bist_led_engine
  import bist_led_pkg::*;
#(
  parameter int unsigned LED_W       = 16,
  parameter int unsigned DIV         = 4,
  parameter logic [31:0] LFSR_SEED   = 32'h0000ACE1,
  parameter int unsigned SWEEP_STEPS = 32
) (
  input logic               clk,
  input logic               rst,
  bist_led_engine_if.slave  led_if
);
  localparam logic [LED_W-1:0] TAPS      = LED_W'(lfsr_taps(LED_W));
  localparam logic [LED_W-1:0] SEED_RAW  = LFSR_SEED[LED_W-1:0];
  localparam logic [LED_W-1:0] LFSR_INIT = (SEED_RAW == '0) ? LED_W'(1) : SEED_RAW;
  localparam int unsigned      SCW       = (SWEEP_STEPS > 1) ? $clog2(SWEEP_STEPS) : 1;
  localparam logic [SCW-1:0]   CNT_LAST  = SCW'(SWEEP_STEPS - 2);
  // With one step per sub-mode every tick is an advance tick.
  localparam sweep_state_e     SUB_ENTRY = (SWEEP_STEPS == 1) ? SW_ADVANCE : SW_RUN;

  function automatic logic [LED_W-1:0] seed_of(input logic [2:0] m);
    return LED_W'(mode_seed(m, 32'(LFSR_INIT)));
  endfunction

  function automatic logic [LED_W-1:0] lfsr_next(input logic [LED_W-1:0] s);
    return {^(s & TAPS), s[LED_W-1:1]};
  endfunction

  logic [2:0]       mode_q, mode_d;
  logic [2:0]       sub_q, sub_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             dir_q, dir_d;      // ping-pong direction, 1 = moving down
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic [SCW-1:0]   cnt_q, cnt_d;
  sweep_state_e     state_q, state_d;

  logic             mode_change;
  logic             step;
  logic [2:0]       pat;
  logic [2:0]       nxt_sub;
  logic [LED_W-1:0] stepped;
  logic             step_dir;

  assign mode_change = (led_if.mode != mode_q);

  bist_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .clear_i (mode_change),
    .hold_i  (led_if.hold),
    .step_o  (step)
  );

`ifdef BIST_MISR_EN
  logic [LED_W-1:0] sig_q, sig_d;
`endif

  always_comb begin
    mode_d   = mode_q;
    sub_d    = sub_q;
    led_d    = led_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    stepped  = '0;
    step_dir = dir_q;
`ifdef BIST_MISR_EN
    sig_d    = sig_q;
`endif

    pat     = (state_q == SW_IDLE) ? mode_q : sub_q;
    nxt_sub = (sub_q == MODE_BLINK) ? MODE_WALK : sub_q + 3'd1;

    case (pat)
      MODE_WALK:  stepped = {led_q[LED_W-2:0], led_q[LED_W-1]};
      MODE_COUNT: stepped = led_q + 1'b1;
      MODE_LFSR:  stepped = lfsr_next(led_q);
      MODE_PING: begin
        // Turn around on reaching an end so endpoints are shown only once.
        stepped  = dir_q ? (led_q >> 1) : (led_q << 1);
        step_dir = dir_q ? ~stepped[0] : stepped[LED_W-1];
      end
      MODE_BLINK: stepped = ~led_q;
      default:    stepped = '0;
    endcase

    if (mode_change) begin
      // Seed load wins over any coincident tick and is not blocked by hold.
      mode_d = led_if.mode;
      dir_d  = 1'b0;
      cnt_d  = '0;
      sub_d  = MODE_WALK;
      if (led_if.mode == MODE_SWEEP) begin
        state_d = SUB_ENTRY;
        led_d   = seed_of(MODE_WALK);
      end else begin
        state_d = SW_IDLE;
        led_d   = seed_of(led_if.mode);
      end
`ifdef BIST_MISR_EN
      sig_d = '0;
`endif
    end else if (step) begin
      tick_d = 1'b1;
      case (state_q)
        SW_ADVANCE: begin
          // Last tick of a sub-mode loads the next seed instead of stepping.
          sub_d   = nxt_sub;
          led_d   = seed_of(nxt_sub);
          dir_d   = 1'b0;
          cnt_d   = '0;
          state_d = SUB_ENTRY;
          done_d  = (sub_q == MODE_BLINK);
        end
        SW_RUN: begin
          led_d = stepped;
          dir_d = step_dir;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = SW_ADVANCE;
        end
        default: begin
          led_d = stepped;
          dir_d = step_dir;
        end
      endcase
`ifdef BIST_MISR_EN
      sig_d = done_d ? '0 : (lfsr_next(sig_q) ^ led_d);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_OFF;
      sub_q   <= MODE_OFF;
      led_q   <= '0;
      dir_q   <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      state_q <= SW_IDLE;
    end else begin
      mode_q  <= mode_d;
      sub_q   <= sub_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

`ifdef BIST_MISR_EN
  always_ff @(posedge clk) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end
  assign led_if.signature = sig_q;
`endif

  // Reserved code runs as off, so it is reported as off.
  assign led_if.mode_active = (state_q != SW_IDLE) ? sub_q :
                              ((mode_q == MODE_RSVD) ? MODE_OFF : mode_q);
  assign led_if.led         = led_q;
  assign led_if.tick        = tick_q;
  assign led_if.sweep_done  = done_q;

endmodule
